assoc_cache: RTL and testbench

ASSOC_CACHE -- requirements
Module: assoc_cache

---
 rtl/assoc_cache.sv | 150 +++++++++++++++
 tb/tb_assoc_cache.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/assoc_cache.sv
// Fully-associative tag/data cache with FIFO replacement and a sequential flush.
// Reads respond one cycle after acceptance; writes update in place on hit or allocate on miss.
module assoc_cache #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int ENTRIES    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]          req_wdata,
  input  logic                           flush,
  output logic                           resp_valid,
  output logic                           resp_hit,
  output logic [DATA_WIDTH-1:0]          resp_rdata,
  output logic [$clog2(ENTRIES+1)-1:0]   count
);

  localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CW = $clog2(ENTRIES + 1);
  localparam logic [CW-1:0] FULL     = CW'(ENTRIES);
  localparam logic [PW-1:0] LAST_IDX = PW'(ENTRIES - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [PW-1:0]           fidx_q, fidx_d;
  logic [CW-1:0]           count_q, count_d;
  logic [ENTRIES-1:0]      valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]   tag_q  [ENTRIES];
  logic [ADDR_WIDTH-1:0]   tag_d  [ENTRIES];
  logic [DATA_WIDTH-1:0]   data_q [ENTRIES];
  logic [DATA_WIDTH-1:0]   data_d [ENTRIES];
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_hit_q, resp_hit_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;

  logic [ENTRIES-1:0]      hit_vec;
  logic                    hit;
  logic [PW-1:0]           hit_idx;
  logic [DATA_WIDTH-1:0]   hit_data;
  logic                    accept;

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
      assign hit_vec[gi] = valid_q[gi] && (tag_q[gi] == req_addr);
    end
  endgenerate

  // Tags are never duplicated, so hit_vec is one-hot and OR-reduction selects the line.
  always_comb begin
    hit_idx  = '0;
    hit_data = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (hit_vec[i]) begin
        hit_idx  = hit_idx | PW'(i);
        hit_data = hit_data | data_q[i];
      end
    end
  end

  assign hit       = |hit_vec;
  assign req_ready = (state_q == IDLE) && !flush;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    fidx_d       = fidx_q;
    count_d      = count_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = FLUSH;
          fidx_d  = '0;
        end else if (accept) begin
          if (req_write) begin
            if (hit) begin
              data_d[hit_idx] = req_wdata;
            end else begin
              tag_d[ptr_q]   = req_addr;
              data_d[ptr_q]  = req_wdata;
              valid_d[ptr_q] = 1'b1;
              ptr_d          = ptr_q + 1'b1;
              if (count_q != FULL) count_d = count_q + 1'b1;
            end
          end else begin
            resp_valid_d = 1'b1;
            resp_hit_d   = hit;
            resp_rdata_d = hit_data;
          end
        end
      end
      FLUSH: begin
        valid_d[fidx_q] = 1'b0;
        fidx_d          = fidx_q + 1'b1;
        if (fidx_q == LAST_IDX) begin
          state_d = IDLE;
          count_d = '0;
          ptr_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      fidx_q       <= '0;
      count_q      <= '0;
      valid_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      fidx_q       <= fidx_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Tag and data contents are qualified by valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_rdata = resp_rdata_q;
  assign count      = count_q;

endmodule

// File: tb/tb_assoc_cache.sv
// Directed testbench for assoc_cache with four lines.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_assoc_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_hit;
  logic [15:0] resp_rdata;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  assoc_cache #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .ENTRIES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .flush(flush), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .resp_rdata(resp_rdata), .count(count)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; returns at the next falling edge.
  task automatic wr(input logic [9:0] a, input logic [15:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, output logic v, output logic h, output logic [15:0] d);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
    v = resp_valid; h = resp_hit; d = resp_rdata;
    $display("read addr=%h valid=%0b hit=%0b data=%h count=%0d", a, v, h, d, count);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%0b exp=0", resp_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", req_ready); end
    $display("reset released ready=%0b count=%0d", req_ready, count);
  endtask

  task automatic test_write_read();
    logic v, h; logic [15:0] d;
    wr(10'h010, 16'h1234);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL write_no_resp got=%0b exp=0", resp_valid); end
    rd(10'h010, v, h, d);
    checks++; if ({v, h, d} !== {1'b1, 1'b1, 16'h1234}) begin errors++; $display("FAIL write_read got=v%0b h%0b %h exp=v1 h1 1234", v, h, d); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL write_read_count got=%0d exp=1", count); end
  endtask

  task automatic test_miss_empty();
    logic v, h; logic [15:0] d;
    apply_reset();
    rd(10'h3FF, v, h, d);
    checks++; if ({v, h, d} !== {1'b1, 1'b0, 16'h0000}) begin errors++; $display("FAIL miss_empty got=v%0b h%0b %h exp=v1 h0 0000", v, h, d); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL miss_empty_count got=%0d exp=0", count); end
  endtask

  task automatic test_fifo_evict();
    logic v, h; logic [15:0] d;
    apply_reset();
    for (int i = 1; i <= 5; i++) wr(10'(i), 16'hA000 + 16'(i));
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL evict_count got=%0d exp=4", count); end
    rd(10'h001, v, h, d);
    checks++; if ({v, h, d} !== {1'b1, 1'b0, 16'h0000}) begin errors++; $display("FAIL evict_oldest got=v%0b h%0b %h exp=v1 h0 0000", v, h, d); end
    // back-to-back reads give back-to-back responses
    for (int i = 2; i <= 5; i++) begin
      rd(10'(i), v, h, d);
      checks++; if ({v, h, d} !== {1'b1, 1'b1, 16'hA000 + 16'(i)}) begin errors++; $display("FAIL evict_hit_%0d got=v%0b h%0b %h exp=v1 h1 %h", i, v, h, d, 16'hA000 + 16'(i)); end
    end
  endtask

  task automatic test_overwrite();
    logic v, h; logic [15:0] d;
    apply_reset();
    wr(10'h007, 16'hAAAA);
    wr(10'h007, 16'hBBBB);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL overwrite_count got=%0d exp=1", count); end
    rd(10'h007, v, h, d);
    checks++; if ({v, h, d} !== {1'b1, 1'b1, 16'hBBBB}) begin errors++; $display("FAIL overwrite_data got=v%0b h%0b %h exp=v1 h1 bbbb", v, h, d); end
    // a write hit must not advance the pointer: line 0 (0x007) is the next victim
    wr(10'h008, 16'h0008); wr(10'h009, 16'h0009); wr(10'h00A, 16'h000A); wr(10'h00B, 16'h000B);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL overwrite_full_count got=%0d exp=4", count); end
    rd(10'h007, v, h, d);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL overwrite_victim got=h%0b exp=h0", h); end
    rd(10'h008, v, h, d);
    checks++; if ({h, d} !== {1'b1, 16'h0008}) begin errors++; $display("FAIL overwrite_survivor got=h%0b %h exp=h1 0008", h, d); end
  endtask

  task automatic test_flush();
    logic v, h; logic [15:0] d;
    int lows;
    logic saw_resp;
    apply_reset();
    for (int i = 1; i <= 4; i++) wr(10'(i), 16'hC000 + 16'(i));
    flush = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h020; req_wdata = 16'hDEAD;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_entry got=%0b exp=0", req_ready); end
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    lows = 0; saw_resp = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) break;
      lows++;
      if (resp_valid) saw_resp = 1'b1;
      @(negedge clk);
    end
    $display("flush done ready_low_cycles=%0d count=%0d", lows, count);
    checks++; if (lows != 4) begin errors++; $display("FAIL flush_duration got=%0d exp=4", lows); end
    checks++; if (saw_resp !== 1'b0) begin errors++; $display("FAIL flush_resp_valid got=1 exp=0"); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
    for (int i = 1; i <= 4; i++) begin
      rd(10'(i), v, h, d);
      checks++; if ({v, h, d} !== {1'b1, 1'b0, 16'h0000}) begin errors++; $display("FAIL flush_miss_%0d got=v%0b h%0b %h exp=v1 h0 0000", i, v, h, d); end
    end
    rd(10'h020, v, h, d);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL flush_blocked_write got=h%0b exp=h0", h); end
    wr(10'h030, 16'h3030);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL flush_restart_count got=%0d exp=1", count); end
  endtask

  task automatic test_async_reset();
    logic v, h; logic [15:0] d;
    apply_reset();
    wr(10'h011, 16'h1111);
    wr(10'h022, 16'h2222);
    rd(10'h022, v, h, d);
    #2 rst = 1'b1;
    #1;
    checks++; if ({resp_valid, resp_hit, resp_rdata, count} !== {1'b0, 1'b0, 16'h0000, 3'd0}) begin errors++; $display("FAIL async_rst_resp got=v%0b h%0b %h c%0d exp=zeros", resp_valid, resp_hit, resp_rdata, count); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wr(10'h011, 16'h1111);
    wr(10'h022, 16'h2222);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if ({resp_valid, count} !== {1'b0, 3'd0}) begin errors++; $display("FAIL async_rst_flush got=v%0b c%0d exp=v0 c0", resp_valid, count); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL async_rst_ready got=%0b exp=1", req_ready); end
    rd(10'h011, v, h, d);
    checks++; if ({v, h} !== {1'b1, 1'b0}) begin errors++; $display("FAIL async_rst_miss_a got=v%0b h%0b exp=v1 h0", v, h); end
    rd(10'h022, v, h, d);
    checks++; if ({v, h} !== {1'b1, 1'b0}) begin errors++; $display("FAIL async_rst_miss_b got=v%0b h%0b exp=v1 h0", v, h); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_write_read();
    test_miss_empty();
    test_fifo_evict();
    test_overwrite();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
